// File: rtl/score_pkg.sv
// Shared widths, display codes, FSM states and the operand saturation helper
// for the score display controller.
package score_pkg;
    localparam int SCORE_W = 7;
    localparam int BCD_W   = 4;

    localparam logic [SCORE_W-1:0] SCORE_MAX  = 7'd99;
    localparam logic [BCD_W-1:0]   BLANK_CODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ_A  = 3'd1,
        ST_WAIT_A = 3'd2,
        ST_REQ_B  = 3'd3,
        ST_WAIT_B = 3'd4
    } state_t;

    // Two decimal digits cannot show more than 99, so larger scores clamp.
    function automatic logic [SCORE_W-1:0] sat_score(input logic [SCORE_W-1:0] s);
        return (s > SCORE_MAX) ? SCORE_MAX : s;
    endfunction
endpackage

// File: rtl/score_display_ctrl_if.sv
// Handshake between the controller (master) and the shared binary-to-BCD
// converter (slave).
interface score_display_ctrl_if;
    import score_pkg::*;

    logic               conv_start_o;
    logic [SCORE_W-1:0] conv_bin_o;
    logic               conv_done_i;
    logic [BCD_W-1:0]   conv_tens_i;
    logic [BCD_W-1:0]   conv_ones_i;

    modport master (
        output conv_start_o, conv_bin_o,
        input  conv_done_i, conv_tens_i, conv_ones_i
    );

    modport slave (
        input  conv_start_o, conv_bin_o,
        output conv_done_i, conv_tens_i, conv_ones_i
    );
endinterface

// File: rtl/display_scan.sv
// Free-running digit scanner: holds each position for REFRESH_DIV clocks,
// rotates the one-hot select and muxes the matching BCD digit.
module display_scan
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [BCD_W-1:0] i_a_tens,
    input  logic [BCD_W-1:0] i_a_ones,
    input  logic [BCD_W-1:0] i_b_tens,
    input  logic [BCD_W-1:0] i_b_ones,
    output logic [BCD_W-1:0] o_digit,
    output logic [3:0]       o_digit_sel
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_sel;
    logic [BCD_W-1:0] w_digit;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_sel <= 4'b0001;
        end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
            r_cnt <= '0;
            r_sel <= {r_sel[2:0], r_sel[3]};
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Tens positions blank a leading zero; ones positions always show.
    always_comb begin
        w_digit = BLANK_CODE;
        case (r_sel)
            4'b0001: w_digit = (i_a_tens == '0) ? BLANK_CODE : i_a_tens;
            4'b0010: w_digit = i_a_ones;
            4'b0100: w_digit = (i_b_tens == '0) ? BLANK_CODE : i_b_tens;
            4'b1000: w_digit = i_b_ones;
            default: w_digit = BLANK_CODE;
        endcase
    end

    assign o_digit     = w_digit;
    assign o_digit_sel = r_sel;
endmodule

// File: rtl/score_display_ctrl.sv
// Arbitrates one shared BCD converter between the two team scores, keeps the
// converted digits in display registers and feeds the digit scanner.
module score_display_ctrl
    import score_pkg::*;
#(
    parameter int REFRESH_DIV = 1024,
    parameter int TIMEOUT     = 64
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SCORE_W-1:0]  score_a_i,
    input  logic [SCORE_W-1:0]  score_b_i,
    score_display_ctrl_if.master conv,
    output logic [BCD_W-1:0]    digit_o,
    output logic [3:0]          digit_sel_o,
    output logic                err_o
);
    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    // The deadline counts from the start pulse, so the last WAIT cycle sees TIMEOUT-2.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 2);

    state_t             r_state, w_state_nxt;
    logic [SCORE_W-1:0] r_bin, r_last_a, r_last_b;
    logic               r_force_a, r_force_b, r_err;
    logic [TMO_W-1:0]   r_tmo;
    logic [BCD_W-1:0]   r_a_tens, r_a_ones, r_b_tens, r_b_ones;

    logic [SCORE_W-1:0] w_sat_a, w_sat_b;
    logic               w_dirty_a, w_dirty_b, w_tmo_end;
    logic               w_load_a, w_load_b, w_commit_a, w_commit_b, w_tmo_a, w_tmo_b;

    assign w_sat_a   = sat_score(score_a_i);
    assign w_sat_b   = sat_score(score_b_i);
    assign w_dirty_a = r_force_a | (w_sat_a != r_last_a);
    assign w_dirty_b = r_force_b | (w_sat_b != r_last_b);
    assign w_tmo_end = (r_tmo == TMO_LAST);

    // Operand is loaded on the edge entering REQ so it is already valid with the start pulse.
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_commit_a  = 1'b0;
        w_commit_b  = 1'b0;
        w_tmo_a     = 1'b0;
        w_tmo_b     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_dirty_a) begin
                    w_state_nxt = ST_REQ_A;
                    w_load_a    = 1'b1;
                end else if (w_dirty_b) begin
                    w_state_nxt = ST_REQ_B;
                    w_load_b    = 1'b1;
                end
            end
            ST_REQ_A: w_state_nxt = ST_WAIT_A;
            ST_WAIT_A: begin
                if (conv.conv_done_i) begin
                    w_commit_a = 1'b1;
                    if (w_dirty_b) begin
                        w_state_nxt = ST_REQ_B;
                        w_load_b    = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_tmo_end) begin
                    w_tmo_a     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_REQ_B: w_state_nxt = ST_WAIT_B;
            ST_WAIT_B: begin
                if (conv.conv_done_i) begin
                    w_commit_b  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_end) begin
                    w_tmo_b     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_bin     <= '0;
            r_last_a  <= '0;
            r_last_b  <= '0;
            r_force_a <= 1'b1;
            r_force_b <= 1'b1;
            r_err     <= 1'b0;
            r_tmo     <= '0;
            r_a_tens  <= '0;
            r_a_ones  <= '0;
            r_b_tens  <= '0;
            r_b_ones  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_a) begin
                r_bin     <= w_sat_a;
                r_last_a  <= w_sat_a;
                r_force_a <= 1'b0;
            end
            if (w_load_b) begin
                r_bin     <= w_sat_b;
                r_last_b  <= w_sat_b;
                r_force_b <= 1'b0;
            end
            if (r_state == ST_REQ_A || r_state == ST_REQ_B)
                r_tmo <= '0;
            else if (r_state == ST_WAIT_A || r_state == ST_WAIT_B)
                r_tmo <= r_tmo + 1'b1;
            if (w_commit_a) begin
                r_a_tens <= conv.conv_tens_i;
                r_a_ones <= conv.conv_ones_i;
            end
            if (w_commit_b) begin
                r_b_tens <= conv.conv_tens_i;
                r_b_ones <= conv.conv_ones_i;
            end
            // An aborted conversion is retried by forcing its team dirty again.
            if (w_tmo_a) begin
                r_err     <= 1'b1;
                r_force_a <= 1'b1;
            end
            if (w_tmo_b) begin
                r_err     <= 1'b1;
                r_force_b <= 1'b1;
            end
        end
    end

    assign conv.conv_start_o = (r_state == ST_REQ_A) || (r_state == ST_REQ_B);
    assign conv.conv_bin_o   = r_bin;
    assign err_o             = r_err;

    display_scan #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_scan (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_a_tens    (r_a_tens),
        .i_a_ones    (r_a_ones),
        .i_b_tens    (r_b_tens),
        .i_b_ones    (r_b_ones),
        .o_digit     (digit_o),
        .o_digit_sel (digit_sel_o)
    );
endmodule

// File: tb/tb_score_display_ctrl.sv
// Bench for score_display_ctrl: a converter model answers start pulses from an
// expected-request queue, and a cycle model predicts scan, digits and error flag.
module tb_score_display_ctrl;
    import score_pkg::*;

    localparam int DIV = 4;
    localparam int TMO = 64;
    localparam int LAT = 14;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] score_a = '0;
    logic [6:0] score_b = '0;
    logic [3:0] digit, sel;
    logic       err;

    score_display_ctrl_if cif();

    score_display_ctrl #(.REFRESH_DIV(DIV), .TIMEOUT(TMO)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .score_a_i   (score_a),
        .score_b_i   (score_b),
        .conv        (cif),
        .digit_o     (digit),
        .digit_sel_o (sel),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit team;   // 0 = A, 1 = B
        int op;
        bit drop;   // converter never answers this request
    } req_t;

    req_t exp_q[$];
    req_t cur;
    int   st_cyc[$];
    int   cyc, s_cyc, mva, mvb;
    bit   merr, outst, commit;
    int   nchk = 0;
    int   npass = 0;

    initial begin
        cif.conv_done_i = 1'b0;
        cif.conv_tens_i = '0;
        cif.conv_ones_i = '0;
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int exp_digit(input int pos, input int va, input int vb);
        int v;
        v = (pos < 2) ? va : vb;
        if (pos % 2 == 0) return (v / 10 == 0) ? 15 : v / 10;
        return v % 10;
    endfunction

    // Cycle model and converter: compare first, then react to this cycle's start.
    always @(negedge clk) begin
        if (rst) begin
            cyc = 0; mva = 0; mvb = 0; merr = 1'b0;
            outst = 1'b0; commit = 1'b0;
            exp_q.delete();
            st_cyc.delete();
            cif.conv_done_i = 1'b0;
        end else begin
            if (commit) begin
                if (cur.team) mvb = cur.op;
                else mva = cur.op;
                commit = 1'b0;
            end
            if (outst && cur.drop && cyc == s_cyc + TMO) begin
                merr  = 1'b1;
                outst = 1'b0;
            end
            chk("digit_sel", int'(sel), 1 << ((cyc / DIV) % 4));
            chk("digit", int'(digit), exp_digit((cyc / DIV) % 4, mva, mvb));
            chk("err", int'(err), int'(merr));
            if (outst) chk("conv_bin_hold", int'(cif.conv_bin_o), cur.op);
            if (cif.conv_start_o) begin
                if (outst || exp_q.size() == 0) begin
                    chk("unexpected_start", int'(cif.conv_start_o), 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("start_operand", int'(cif.conv_bin_o), cur.op);
                    outst = 1'b1;
                    s_cyc = cyc;
                    st_cyc.push_back(cyc);
                end
            end
            cif.conv_done_i = 1'b0;
            if (outst && !cur.drop && cyc == s_cyc + LAT) begin
                cif.conv_done_i = 1'b1;
                cif.conv_tens_i = 4'(cur.op / 10);
                cif.conv_ones_i = 4'(cur.op % 10);
                commit = 1'b1;
                outst  = 1'b0;
            end
            cyc++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input bit team, input int op, input bit drop);
        req_t r;
        r.team = team; r.op = op; r.drop = drop;
        exp_q.push_back(r);
    endtask

    // Waits for all expected requests to finish, then idles so stray starts show up.
    task automatic wait_quiet(input string name, input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || outst || commit) && k < bound) begin
            tick(1);
            k++;
        end
        chk({name, "_pending"}, exp_q.size() + int'(outst), 0);
        tick(40);
    endtask

    task automatic wait_qsize(input string name, input int n, input int bound);
        int k = 0;
        while (exp_q.size() != n && k < bound) begin
            tick(1);
            k++;
        end
        chk({name, "_started"}, exp_q.size(), n);
    endtask

    task automatic check_disp(input string name, input int d0, input int d1, input int d2, input int d3);
        int e[4];
        int k;
        e = '{d0, d1, d2, d3};
        for (int p = 0; p < 4; p++) begin
            k = 0;
            while (sel != 4'(1 << p) && k < 4 * DIV + 4) begin
                tick(1);
                k++;
            end
            chk($sformatf("%s_sel%0d", name, p), int'(sel), 1 << p);
            chk($sformatf("%s_digit%0d", name, p), int'(digit), e[p]);
        end
    endtask

    task automatic check_starts(input string name, input int c0, input int c1);
        chk({name, "_nstarts"}, st_cyc.size(), 2);
        if (st_cyc.size() >= 2) begin
            chk({name, "_first_start_cyc"}, st_cyc[0], c0);
            chk({name, "_second_start_cyc"}, st_cyc[1], c1);
        end
    endtask

    initial begin
        // 1: reset state, then A=42, B=7 from reset release
        score_a = 7'd42;
        score_b = 7'd7;
        tick(3);
        chk("rst_start", int'(cif.conv_start_o), 0);
        chk("rst_bin", int'(cif.conv_bin_o), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_sel", int'(sel), 1);
        chk("rst_digit", int'(digit), 15);
        push(1'b0, 42, 1'b0);
        push(1'b1, 7, 1'b0);
        rst = 1'b0;
        wait_quiet("s1", 200);
        check_starts("s1", 1, 16);
        check_disp("s1", 4, 2, 15, 7);

        // 2: only A changes
        push(1'b0, 43, 1'b0);
        score_a = 7'd43;
        wait_quiet("s2", 200);
        check_disp("s2", 4, 3, 15, 7);

        // 3: saturation
        push(1'b0, 99, 1'b0);
        score_a = 7'd120;
        wait_quiet("s3", 200);
        check_disp("s3", 9, 9, 15, 7);

        // 4: converter ignores B once; digits hold, err sets, B is retried
        push(1'b1, 8, 1'b1);
        push(1'b1, 8, 1'b0);
        score_b = 7'd8;
        wait_qsize("s4", 1, 100);
        tick(20);
        chk("s4_err_before", int'(err), 0);
        check_disp("s4_hold", 9, 9, 15, 7);
        begin
            int k = 0;
            while (!err && k < 200) begin
                tick(1);
                k++;
            end
        end
        chk("s4_err_set", int'(err), 1);
        wait_quiet("s4", 300);
        check_disp("s4", 9, 9, 15, 8);
        chk("s4_err_sticky", int'(err), 1);

        // 5: A changes during WAIT_A
        push(1'b0, 10, 1'b0);
        push(1'b0, 11, 1'b0);
        score_a = 7'd10;
        wait_qsize("s5", 1, 100);
        tick(5);
        score_a = 7'd11;
        wait_quiet("s5", 300);
        check_disp("s5", 1, 1, 15, 8);

        // 6: asynchronous reset mid-WAIT, then restart like scenario 1
        push(1'b0, 55, 1'b0);
        score_a = 7'd55;
        wait_qsize("s6", 0, 100);
        tick(5);
        rst = 1'b1;
        #1;
        chk("s6_async_start", int'(cif.conv_start_o), 0);
        chk("s6_async_bin", int'(cif.conv_bin_o), 0);
        chk("s6_async_err", int'(err), 0);
        chk("s6_async_sel", int'(sel), 1);
        chk("s6_async_digit", int'(digit), 15);
        tick(2);
        score_a = 7'd42;
        score_b = 7'd7;
        push(1'b0, 42, 1'b0);
        push(1'b1, 7, 1'b0);
        rst = 1'b0;
        wait_quiet("s6", 200);
        check_starts("s6", 1, 16);
        check_disp("s6", 4, 2, 15, 7);
        chk("s6_err", int'(err), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
